// File: rtl/datamover_tcdm_responder_pkg.sv
// Shared types and helpers for the datamover TCDM responder model.
// Flags bundle, default LFSR seed and the LFSR step function.
package datamover_tcdm_responder_pkg;

  localparam int unsigned OUT_W = 8;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef struct packed {
    logic [31:0]      nb_reads;
    logic [31:0]      nb_writes;
    logic [OUT_W-1:0] outstanding;
  } flags_tcdm_responder_t;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/datamover_tcdm_responder_fifo.sv
// Fall-through response FIFO: head entry is visible while non-empty.
// Holds {r_data, r_user, r_id}; pointers and count reset synchronously.
module datamover_tcdm_responder_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wrap_inc(wptr_q);
    if (do_pop)  rptr_d = wrap_inc(rptr_q);
    unique case (1'b1)
      (do_push && !do_pop): cnt_d = cnt_q + CW'(1);
      (do_pop && !do_push): cnt_d = cnt_q - CW'(1);
      default:              cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/datamover_tcdm_responder.sv
// Single-bank TCDM target model with latency, random grant stalls
// and r_ready backpressure, answering HCI core requests in order.
module datamover_tcdm_responder
  import datamover_tcdm_responder_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned NB_WORDS   = 1024,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned RESP_DEPTH = 2,
  parameter bit          WRITE_RESP = 1'b0,
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter int unsigned UW         = 4,
  parameter int unsigned IW         = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            stall_prob_i,
  input  logic                  tcdm_req_i,
  output logic                  tcdm_gnt_o,
  input  logic [AW-1:0]         tcdm_add_i,
  input  logic                  tcdm_wen_i,
  input  logic [DW/8-1:0]       tcdm_be_i,
  input  logic [DW-1:0]         tcdm_data_i,
  input  logic [UW-1:0]         tcdm_user_i,
  input  logic [IW-1:0]         tcdm_id_i,
  output logic [DW-1:0]         tcdm_r_data_o,
  output logic                  tcdm_r_valid_o,
  input  logic                  tcdm_r_ready_i,
  output logic [UW-1:0]         tcdm_r_user_o,
  output logic [IW-1:0]         tcdm_r_id_o,
  output flags_tcdm_responder_t flags_o
);

  localparam int unsigned BW  = DW / 8;
  localparam int unsigned OFF = $clog2(BW);
  localparam int unsigned IXW = $clog2(NB_WORDS);
  localparam int unsigned EW  = DW + UW + IW;

  logic [DW-1:0]    mem_q [NB_WORDS];
  logic [15:0]      lfsr_q, lfsr_d;
  logic [31:0]      nrd_q, nrd_d;
  logic [31:0]      nwr_q, nwr_d;
  logic [OUT_W-1:0] outst_q, outst_d;

  logic [IXW-1:0] idx;
  logic           stall, acc, rd_acc, wr_acc;
  logic           rsp_in, push, pop;
  logic           fifo_full, fifo_empty;
  logic [EW-1:0]  in_ent, push_ent, head_ent;
  logic           unused_add;

  assign idx        = tcdm_add_i[OFF +: IXW];
  assign unused_add = ^tcdm_add_i;

  // Grant looks only at stall and occupancy, never at r_ready
  assign stall      = (lfsr_q[3:0] < stall_prob_i);
  assign tcdm_gnt_o = !rst_i && !stall &&
                      (outst_q < OUT_W'(RESP_DEPTH));

  assign acc    = tcdm_req_i && tcdm_gnt_o;
  assign rd_acc = acc && tcdm_wen_i;
  assign wr_acc = acc && !tcdm_wen_i;
  assign rsp_in = rd_acc || (wr_acc && WRITE_RESP);
  assign in_ent = {tcdm_wen_i ? mem_q[idx] : '0,
                   tcdm_user_i, tcdm_id_i};

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < BW; b++) begin
        if (tcdm_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
        end
      end
    end
  end

  // LATENCY-1 register stages; the FIFO adds the last cycle
  if (LATENCY == 1) begin : g_direct
    assign push     = rsp_in;
    assign push_ent = in_ent;
  end else begin : g_dline
    logic [LATENCY-2:0] vld_q;
    logic [EW-1:0]      ent_q [LATENCY-1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rsp_in;
        for (int i = 1; i < LATENCY - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      ent_q[0] <= in_ent;
      for (int i = 1; i < LATENCY - 1; i++) begin
        ent_q[i] <= ent_q[i-1];
      end
    end

    assign push     = vld_q[LATENCY-2];
    assign push_ent = ent_q[LATENCY-2];
  end

  datamover_tcdm_responder_fifo #(
    .W     (EW),
    .DEPTH (RESP_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push && !fifo_full),
    .data_i  (push_ent),
    .pop_i   (tcdm_r_ready_i),
    .data_o  (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tcdm_r_valid_o = !fifo_empty;
  assign pop = tcdm_r_valid_o && tcdm_r_ready_i;
  assign {tcdm_r_data_o, tcdm_r_user_o, tcdm_r_id_o} = head_ent;

  always_comb begin
    lfsr_d  = lfsr_next(lfsr_q);
    nrd_d   = nrd_q;
    nwr_d   = nwr_q;
    outst_d = outst_q;
    if (rd_acc) nrd_d = nrd_q + 32'd1;
    if (wr_acc) nwr_d = nwr_q + 32'd1;
    unique case (1'b1)
      (rsp_in && !pop): outst_d = outst_q + OUT_W'(1);
      (pop && !rsp_in): outst_d = outst_q - OUT_W'(1);
      default:          outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q  <= SEED;
      nrd_q   <= '0;
      nwr_q   <= '0;
      outst_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      outst_q <= outst_d;
    end
  end

  assign flags_o.nb_reads    = nrd_q;
  assign flags_o.nb_writes   = nwr_q;
  assign flags_o.outstanding = outst_q;

endmodule

// File: tb/tb_datamover_tcdm_responder.sv
// Directed bench for the TCDM responder: one LATENCY=1 instance
// and one LATENCY=3 instance with write responses enabled.
module tb_datamover_tcdm_responder;
  import datamover_tcdm_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        a_req, a_gnt, a_wen, a_rvalid, a_rready;
  logic [31:0] a_add, a_data, a_rdata;
  logic [3:0]  a_be, a_user, a_ruser, a_stall;
  logic [7:0]  a_id, a_rid;
  flags_tcdm_responder_t a_flags;

  logic        b_req, b_gnt, b_wen, b_rvalid, b_rready;
  logic [31:0] b_add, b_data, b_rdata;
  logic [3:0]  b_be, b_user, b_ruser, b_stall;
  logic [7:0]  b_id, b_rid;
  flags_tcdm_responder_t b_flags;

  datamover_tcdm_responder #(
    .LATENCY(1), .RESP_DEPTH(2), .WRITE_RESP(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .stall_prob_i(a_stall),
    .tcdm_req_i(a_req), .tcdm_gnt_o(a_gnt),
    .tcdm_add_i(a_add), .tcdm_wen_i(a_wen),
    .tcdm_be_i(a_be), .tcdm_data_i(a_data),
    .tcdm_user_i(a_user), .tcdm_id_i(a_id),
    .tcdm_r_data_o(a_rdata), .tcdm_r_valid_o(a_rvalid),
    .tcdm_r_ready_i(a_rready), .tcdm_r_user_o(a_ruser),
    .tcdm_r_id_o(a_rid), .flags_o(a_flags)
  );

  datamover_tcdm_responder #(
    .LATENCY(3), .RESP_DEPTH(4), .WRITE_RESP(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .stall_prob_i(b_stall),
    .tcdm_req_i(b_req), .tcdm_gnt_o(b_gnt),
    .tcdm_add_i(b_add), .tcdm_wen_i(b_wen),
    .tcdm_be_i(b_be), .tcdm_data_i(b_data),
    .tcdm_user_i(b_user), .tcdm_id_i(b_id),
    .tcdm_r_data_o(b_rdata), .tcdm_r_valid_o(b_rvalid),
    .tcdm_r_ready_i(b_rready), .tcdm_r_user_o(b_ruser),
    .tcdm_r_id_o(b_rid), .flags_o(b_flags)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [3:0]  user;
    int          acc;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  exp_t a_q[$];
  exp_t b_q[$];
  logic a_mon = 1'b0;
  int   a_nrd = 0, a_nwr = 0;
  int   b_nrd = 0, b_nwr = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] id,
                              input logic [31:0] data,
                              input int acc);
    exp_t e;
    e.id = id; e.data = data; e.user = id[3:0]; e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (a_mon && a_rvalid && a_rready) begin
      if (a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_resp: got id %0h expected none",
                 a_rid);
      end else begin
        exp_t e;
        e = a_q.pop_front();
        chk("a_rid", a_rid, e.id);
        chk("a_rdata", a_rdata, e.data);
        chk("a_ruser", a_ruser, e.user);
      end
    end
  end

  always @(negedge clk) begin
    if (b_rvalid === 1'b1 && b_rready) begin
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_resp: got id %0h expected none",
                 b_rid);
      end else begin
        exp_t e;
        e = b_q.pop_front();
        chk("b_rid", b_rid, e.id);
        chk("b_rdata", b_rdata, e.data);
        chk("b_ruser", b_ruser, e.user);
        chk("b_latency", cyc_cnt - e.acc, 3);
      end
    end
  end

  task automatic a_send(input logic wen, input logic [31:0] add,
                        input logic [3:0] be, input logic [31:0] data,
                        input logic [7:0] id, input int maxc,
                        output int waited, output int acc);
    a_req = 1'b1; a_wen = wen; a_add = add; a_be = be;
    a_data = data; a_id = id; a_user = id[3:0];
    waited = 0; acc = -1;
    while (waited < maxc) begin
      @(negedge clk);
      if (a_gnt) begin
        acc = cyc_cnt;
        @(posedge clk); #1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    a_req = 1'b0;
    if (acc >= 0) begin
      if (wen) a_nrd++; else a_nwr++;
    end
  endtask

  task automatic b_send(input logic wen, input logic [31:0] add,
                        input logic [31:0] data, input logic [7:0] id,
                        output int waited, output int acc);
    b_req = 1'b1; b_wen = wen; b_add = add; b_be = 4'hF;
    b_data = data; b_id = id; b_user = id[3:0];
    waited = 0; acc = -1;
    while (waited < 8) begin
      @(negedge clk);
      if (b_gnt) begin
        acc = cyc_cnt;
        @(posedge clk); #1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    if (acc >= 0) begin
      if (wen) b_nrd++; else b_nwr++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tv [12];
    logic [31:0] model [16];
    int          w, acc, grants, tot, rate;

    tv[0]  = '{1'b0, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    tv[1]  = '{1'b1, 32'h10,   4'hF, 32'h0, 32'hDEADBEEF};
    tv[2]  = '{1'b0, 32'h20,   4'hF, 32'h11223344, 32'h0};
    tv[3]  = '{1'b0, 32'h20,   4'h5, 32'hAABBCCDD, 32'h0};
    tv[4]  = '{1'b1, 32'h20,   4'hF, 32'h0, 32'h11BB33DD};
    tv[5]  = '{1'b0, 32'h24,   4'hF, 32'h0, 32'h0};
    tv[6]  = '{1'b0, 32'h24,   4'hA, 32'hCAFEF00D, 32'h0};
    tv[7]  = '{1'b1, 32'h24,   4'hF, 32'h0, 32'hCA00F000};
    tv[8]  = '{1'b0, 32'h1024, 4'hF, 32'h55AA55AA, 32'h0};
    tv[9]  = '{1'b1, 32'h27,   4'hF, 32'h0, 32'h55AA55AA};
    tv[10] = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0BADF00D, 32'h0};
    tv[11] = '{1'b1, 32'h0FFC, 4'hF, 32'h0, 32'h0BADF00D};

    rst = 1'b1;
    a_req = 0; a_wen = 0; a_add = 0; a_be = 0; a_data = 0;
    a_id = 0; a_user = 0; a_rready = 1; a_stall = 0;
    b_req = 0; b_wen = 0; b_add = 0; b_be = 0; b_data = 0;
    b_id = 0; b_user = 0; b_rready = 1; b_stall = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_flags", a_flags, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      a_send(tv[i].wen, tv[i].add, tv[i].be, tv[i].data,
             8'(i), 8, w, acc);
      chk("tv_wait", w, 0);
      @(negedge clk);
      if (tv[i].wen) begin
        chk("tv_rvalid", a_rvalid, 1);
        chk("tv_rdata", a_rdata, tv[i].exp);
        chk("tv_rid", a_rid, 8'(i));
      end else begin
        chk("tv_wr_no_resp", a_rvalid, 0);
      end
      @(posedge clk); #1;
    end

    a_send(1'b0, 32'h30, 4'hF, 32'h600DCAFE, 8'd20, 8, w, acc);
    a_send(1'b1, 32'h30, 4'hF, 32'h0, 8'd21, 8, w, acc);
    chk("raw_b2b_wait", w, 0);
    @(negedge clk);
    chk("raw_rvalid", a_rvalid, 1);
    chk("raw_rdata", a_rdata, 32'h600DCAFE);
    chk("raw_rid", a_rid, 8'd21);
    chk("a_nb_reads", a_flags.nb_reads, 32'(a_nrd));
    chk("a_nb_writes", a_flags.nb_writes, 32'(a_nwr));
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      b_send(1'b0, 32'h100 + 32'(4 * i), 32'h0B000000 + 32'(i),
             8'h40 + 8'(i), w, acc);
      chk("b_wr_gnt", w, 0);
      b_q.push_back(mk(8'h40 + 8'(i), 32'h0, acc));
    end
    for (int i = 0; i < 8; i++) begin
      b_send(1'b1, 32'h100 + 32'(4 * i), 32'h0,
             8'h50 + 8'(i), w, acc);
      chk("b_rd_gnt", w, 0);
      b_q.push_back(mk(8'h50 + 8'(i), 32'h0B000000 + 32'(i), acc));
    end
    repeat (6) @(posedge clk);
    #1;
    chk("b_all_returned", b_q.size(), 0);
    chk("b_nb_reads", b_flags.nb_reads, 32'(b_nrd));
    chk("b_nb_writes", b_flags.nb_writes, 32'(b_nwr));
    chk("b_outstanding", b_flags.outstanding, 0);

    for (int i = 0; i < 4; i++) begin
      a_send(1'b0, 32'h40 + 32'(4 * i), 4'hF,
             32'hA0000000 + 32'(i), 8'd0, 8, w, acc);
    end
    a_mon = 1'b1;
    a_rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_send(1'b1, 32'h40 + 32'(4 * i), 4'hF, 32'h0,
             8'h30 + 8'(i), 8, w, acc);
      a_q.push_back(mk(8'h30 + 8'(i), 32'hA0000000 + 32'(i), acc));
    end
    a_send(1'b1, 32'h48, 4'hF, 32'h0, 8'h32, 4, w, acc);
    chk("full_blocks_gnt", (acc < 0), 1);
    @(negedge clk);
    chk("full_outstanding", a_flags.outstanding, 2);
    chk("full_head_id", a_rid, 8'h30);
    @(posedge clk); #1;
    a_rready = 1'b1;
    a_send(1'b1, 32'h48, 4'hF, 32'h0, 8'h32, 8, w, acc);
    chk("gnt_after_pop", w, 1);
    a_q.push_back(mk(8'h32, 32'hA0000002, acc));
    a_send(1'b1, 32'h4C, 4'hF, 32'h0, 8'h33, 8, w, acc);
    a_q.push_back(mk(8'h33, 32'hA0000003, acc));
    repeat (4) @(posedge clk);
    #1;
    chk("bp_all_returned", a_q.size(), 0);

    a_stall = 4'd8;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      a_send(1'b0, 32'h200 + 32'(4 * i), 4'hF, model[i],
             8'd0, 64, w, acc);
    end
    grants = 0; tot = 0;
    for (int i = 0; i < 1000; i++) begin
      logic        wen;
      int          wi;
      logic [3:0]  be;
      logic [31:0] d;
      wen = 1'($urandom_range(0, 1));
      wi = int'($urandom_range(0, 15));
      be = 4'($urandom_range(0, 15));
      d = $urandom;
      a_send(wen, 32'h200 + 32'(4 * wi), be, d, 8'(i), 64, w, acc);
      chk("rnd_granted", (acc >= 0), 1);
      tot += w + 1;
      if (acc >= 0) begin
        grants++;
        if (wen) begin
          a_q.push_back(mk(8'(i), model[wi], acc));
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[b]) model[wi][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
    repeat (4) @(posedge clk);
    #1;
    rate = (grants * 100) / tot;
    chk("rnd_all_returned", a_q.size(), 0);
    chk("rnd_gnt_rate", (rate >= 30 && rate <= 70), 1);
    chk("rnd_nb_reads", a_flags.nb_reads, 32'(a_nrd));
    chk("rnd_nb_writes", a_flags.nb_writes, 32'(a_nwr));

    a_stall = 4'd0;
    a_rready = 1'b0;
    a_send(1'b1, 32'h40, 4'hF, 32'h0, 8'h60, 8, w, acc);
    a_send(1'b1, 32'h44, 4'hF, 32'h0, 8'h61, 8, w, acc);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", a_gnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rvalid", a_rvalid, 0);
    chk("midrst_rdata", a_rdata, 0);
    chk("midrst_outstanding", a_flags.outstanding, 0);
    chk("midrst_nb_reads", a_flags.nb_reads, 0);
    a_nrd = 0; a_nwr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    a_rready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_no_resp", a_rvalid, 0);
    @(posedge clk); #1;
    a_send(1'b1, 32'h10, 4'hF, 32'h0, 8'h70, 8, w, acc);
    a_q.push_back(mk(8'h70, 32'hDEADBEEF, acc));
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_read", a_q.size(), 0);
    chk("post_rst_nb_reads", a_flags.nb_reads, 32'(a_nrd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
